memory_stage: RTL and testbench
===============================

// Module: memory_stage
// PURPOSE
//   SEQ memory stage, directly downstream of execute. Consumes icode/valE/valA/valP
//   and performs the Y86-64 data-memory access. Owns the byte-addressed data RAM.
//   Returns valM for write-back and PC update, plus the processor status code.
//   Holds a sticky halt latch: once status leaves AOK, all further memory writes
//   are blocked until reset.
// PARAMETERS
//   MEM_BYTES  1024  data RAM size in bytes; legal access when addr <= MEM_BYTES-8
// PORTS
//   clk          in   1   system clock, rising edge
//   reset_n      in   1   asynchronous active-low reset
//   icode        in   4   instruction code from fetch
//   instr_valid  in   1   fetch decoded a legal icode/ifun
//   imem_error   in   1   fetch instruction-address error
//   valA         in   64  decode operand A (store data / pop-ret address)
//   valE         in   64  execute result (effective address)
//   valP         in   64  incremented PC (call return address)
//   valM         out  64  loaded word, little-endian
//   dmem_error   out  1   data address out of range for the current access
//   stat         out  3   1=AOK 2=HLT 3=ADR 4=INS
//   halted       out  1   sticky halt latch
// BEHAVIOUR
//   Address select (unsigned 64-bit): rmmovq(4) mrmovq(5) call(8) pushq(A) use valE.
//     ret(9) and popq(B) use valA. All other icodes make no access.
//   Reads: mrmovq, ret, popq. Combinational in the same cycle (SEQ). valM = bytes
//     [addr..addr+7], little-endian. valM = 0 when there is no read or on dmem_error.
//   Writes: rmmovq and pushq store valA; call stores valP. All 8 bytes are written at
//     the rising clk edge.
//   dmem_error = access_active && (addr > MEM_BYTES-8). Compare at full 64-bit
//     width, so no wrap: addr 0xFFFF_FFFF_FFFF_FFF8 is an error.
//   A write is performed only when the instruction writes memory, !dmem_error,
//     !halted, and the combinational stat == AOK.
//   stat priority, when not halted: imem_error|dmem_error -> ADR;
//     else !instr_valid -> INS; else icode==0 -> HLT; else AOK.
//   Halt latch, registered: if !halted and stat != AOK at posedge clk, set halted=1
//     and latch stat. While halted:
//     - stat holds the latched code.
//     - Reads still drive valM.
//     - No writes occur.
//     - New errors do not change stat.
//   Simultaneous fault and write in the same cycle: the write is suppressed and the
//     halt latch is set at the same edge.
//   Reset (reset_n low, async, regardless of clk):
//     - All RAM bytes clear to 0.
//     - halted=0 and the latched stat = AOK.
//     - While reset is held: valM=0, dmem_error=0, stat=AOK, and no writes occur.
//   Reset mid-operation: a write pending at that edge is dropped. Operation
//     restarts at the first posedge after reset_n rises.
//   Latency: reads 0 cycles. Writes become visible to reads in the cycle after
//     their edge.
// TESTING
//   1 Store then load: rmmovq with valE=0x10, valA=0x1122334455667788, one edge;
//     then mrmovq with valE=0x10 -> valM=0x1122334455667788 and byte 0x10 = 0x88.
//   2 call/ret: call with valE=0x3F8, valP=0x2A, edge; then ret with valA=0x3F8 ->
//     valM=0x2A, stat=AOK.
//   3 Boundary: mrmovq at valE=0x3F8 -> dmem_error=0. At 0x3F9 -> dmem_error=1,
//     valM=0, stat=ADR; halted=1 after the edge.
//   4 Sticky halt: icode=0 -> stat=HLT, edge -> halted=1. Then rmmovq to 0x20 ->
//     no write (a later read after reset returns 0). Then imem_error=1 -> stat stays HLT.
//   5 Invalid/no-write: instr_valid=0 with icode=4 -> stat=INS, no write.
//     pushq at valE=0xFFFF_FFFF_FFFF_FFF8 -> ADR, no write.
//   6 Async reset: assert reset_n=0 between edges after storing data -> stat=AOK,
//     halted=0 immediately; a read of the old address returns 0.

Source files
------------

// File: rtl/memory_stage.sv
// memory_stage: SEQ Y86-64 data-memory stage.
// Selects the access address from valE/valA, reads a little-endian 64-bit word
// combinationally, writes 8 bytes at the clock edge, and produces the processor
// status code. A sticky halt latch freezes status and blocks writes once the
// processor leaves AOK, until reset.
module memory_stage #(
  parameter int unsigned MEM_BYTES = 1024
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [3:0]  icode,
  input  logic        instr_valid,
  input  logic        imem_error,
  input  logic [63:0] valA,
  input  logic [63:0] valE,
  input  logic [63:0] valP,
  output logic [63:0] valM,
  output logic        dmem_error,
  output logic [2:0]  stat,
  output logic        halted
);

  localparam int          DATA_W  = 64;
  localparam int          AW      = $clog2(MEM_BYTES);
  // Highest legal base address of an 8-byte access
  localparam logic [63:0] LAST_OK = 64'(MEM_BYTES - 8);

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [2:0] S_AOK = 3'd1;
  localparam logic [2:0] S_HLT = 3'd2;
  localparam logic [2:0] S_ADR = 3'd3;
  localparam logic [2:0] S_INS = 3'd4;

  logic [7:0]        mem_q [MEM_BYTES];
  logic              halted_q, halted_d;
  logic [2:0]        stat_q, stat_d;

  logic [63:0]       addr;
  logic [AW-1:0]     addr_lo;
  logic              access, rd, wr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              addr_err;
  logic [2:0]        stat_now;
  logic              wr_en;

  // Decode the access kind, address source and store data from icode
  always_comb begin
    addr   = '0;
    access = 1'b0;
    rd     = 1'b0;
    wr     = 1'b0;
    wdata  = valA;
    case (icode)
      I_RMMOVQ: begin addr = valE; access = 1'b1; wr = 1'b1; end
      I_MRMOVQ: begin addr = valE; access = 1'b1; rd = 1'b1; end
      I_CALL:   begin addr = valE; access = 1'b1; wr = 1'b1; wdata = valP; end
      I_PUSHQ:  begin addr = valE; access = 1'b1; wr = 1'b1; end
      I_RET:    begin addr = valA; access = 1'b1; rd = 1'b1; end
      I_POPQ:   begin addr = valA; access = 1'b1; rd = 1'b1; end
      default:  begin end
    endcase
  end

  // Full-width range check so a huge address cannot wrap into the RAM
  assign addr_err = access && (addr > LAST_OK);
  assign addr_lo  = addr[AW-1:0];

  // Gather the 8 bytes at addr into a little-endian word
  always_comb begin
    rdata = '0;
    for (int k = 0; k < 8; k++) begin
      rdata[8*k +: 8] = mem_q[addr_lo + AW'(k)];
    end
  end

  // Status: latched code while halted, otherwise the priority-encoded fault
  always_comb begin
    stat_now = S_AOK;
    if (halted_q)                    stat_now = stat_q;
    else if (imem_error || addr_err) stat_now = S_ADR;
    else if (!instr_valid)           stat_now = S_INS;
    else if (icode == I_HALT)        stat_now = S_HLT;
  end

  // A fault in the same cycle as a store suppresses the store
  assign wr_en = wr && !addr_err && !halted_q && (stat_now == S_AOK);

  // Next state of the halt latch: capture the first non-AOK status
  always_comb begin
    halted_d = halted_q;
    stat_d   = stat_q;
    if (!halted_q && (stat_now != S_AOK)) begin
      halted_d = 1'b1;
      stat_d   = stat_now;
    end
  end

  // Halt latch register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      halted_q <= 1'b0;
      stat_q   <= S_AOK;
    end else begin
      halted_q <= halted_d;
      stat_q   <= stat_d;
    end
  end

  // Data RAM: cleared by reset, 8-byte little-endian store at the clock edge
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < MEM_BYTES; i++) begin
        mem_q[i] <= 8'h00;
      end
    end else if (wr_en) begin
      for (int k = 0; k < 8; k++) begin
        mem_q[addr_lo + AW'(k)] <= wdata[8*k +: 8];
      end
    end
  end

  // Outputs are forced quiet while reset is held
  assign valM       = (reset_n && rd && !addr_err) ? rdata : '0;
  assign dmem_error = reset_n && addr_err;
  assign stat       = reset_n ? stat_now : S_AOK;
  assign halted     = halted_q;

endmodule

// File: tb/tb_memory_stage.sv
// tb_memory_stage: directed-vector bench for memory_stage.
module tb_memory_stage;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [3:0]  icode;
  logic        instr_valid;
  logic        imem_error;
  logic [63:0] valA, valE, valP;
  logic [63:0] valM;
  logic        dmem_error;
  logic [2:0]  stat;
  logic        halted;

  int n_checks = 0;
  int n_errors = 0;

  memory_stage #(.MEM_BYTES(1024)) dut (
    .clk(clk), .reset_n(reset_n), .icode(icode), .instr_valid(instr_valid),
    .imem_error(imem_error), .valA(valA), .valE(valE), .valP(valP),
    .valM(valM), .dmem_error(dmem_error), .stat(stat), .halted(halted)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Apply one instruction between edges and let the combinational outputs settle
  task automatic drive(input logic [3:0] ic, input logic [63:0] e = 64'h0,
                       input logic [63:0] a = 64'h0, input logic [63:0] p = 64'h0,
                       input logic iv = 1'b1, input logic ie = 1'b0);
    @(negedge clk);
    icode = ic; valE = e; valA = a; valP = p; instr_valid = iv; imem_error = ie;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Asynchronous reset pulse between edges, with a nop on the inputs
  task automatic pulse_reset();
    drive(4'h1);
    #2 reset_n = 1'b0;
    #1;
    check_eq("rst_stat", 64'(stat), 64'd1);
    check_eq("rst_halted", 64'(halted), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0;
    icode = 4'h5; valE = 64'h3F9; valA = 0; valP = 0; instr_valid = 1'b1; imem_error = 1'b0;
    #3;
    check_eq("init_stat", 64'(stat), 64'd1);
    check_eq("init_halted", 64'(halted), 64'd0);
    check_eq("init_valM", valM, 64'h0);
    check_eq("init_dmem", 64'(dmem_error), 64'd0);
    @(posedge clk); @(posedge clk); #1;
    check_eq("init_hold_halted", 64'(halted), 64'd0);
    drive(4'h1);
    reset_n = 1'b1;

    // Store then load, little-endian byte order
    drive(4'h4, 64'h10, 64'h1122334455667788);
    check_eq("st_stat", 64'(stat), 64'd1);
    check_eq("st_valM", valM, 64'h0);
    tick();
    check_eq("st_halted", 64'(halted), 64'd0);
    drive(4'h5, 64'h10);
    check_eq("ld_valM", valM, 64'h1122334455667788);
    check_eq("ld_byte10", 64'(valM[7:0]), 64'h88);
    drive(4'h5, 64'h0F);
    check_eq("ld_unaligned", valM, 64'h2233445566778800);

    // call / ret
    drive(4'h8, 64'h3F8, 64'h999, 64'h2A);
    check_eq("call_stat", 64'(stat), 64'd1);
    tick();
    drive(4'h9, 64'h5555, 64'h3F8);
    check_eq("ret_valM", valM, 64'h2A);
    check_eq("ret_stat", 64'(stat), 64'd1);

    // push / pop
    drive(4'hA, 64'h100, 64'h0123456789ABCDEF);
    tick();
    drive(4'hB, 64'h108, 64'h100);
    check_eq("pop_valM", valM, 64'h0123456789ABCDEF);

    // Upper boundary
    drive(4'h5, 64'h3F8);
    check_eq("bnd_ok_dmem", 64'(dmem_error), 64'd0);
    check_eq("bnd_ok_valM", valM, 64'h2A);
    drive(4'h5, 64'h3F9);
    check_eq("bnd_err_dmem", 64'(dmem_error), 64'd1);
    check_eq("bnd_err_valM", valM, 64'h0);
    check_eq("bnd_err_stat", 64'(stat), 64'd3);
    check_eq("bnd_pre_halted", 64'(halted), 64'd0);
    tick();
    check_eq("bnd_halted", 64'(halted), 64'd1);
    drive(4'h1);
    check_eq("bnd_stat_held", 64'(stat), 64'd3);
    pulse_reset();

    // Sticky halt
    drive(4'h0);
    check_eq("hlt_stat", 64'(stat), 64'd2);
    tick();
    check_eq("hlt_halted", 64'(halted), 64'd1);
    drive(4'h4, 64'h20, 64'h55);
    check_eq("hlt_st_stat", 64'(stat), 64'd2);
    tick();
    drive(4'h5, 64'h20);
    check_eq("hlt_nowrite", valM, 64'h0);
    drive(4'h1, 64'h0, 64'h0, 64'h0, 1'b1, 1'b1);
    check_eq("hlt_imem_stat", 64'(stat), 64'd2);
    pulse_reset();
    drive(4'h5, 64'h20);
    check_eq("hlt_after_rst", valM, 64'h0);

    // Invalid instruction suppresses its store
    drive(4'h4, 64'h30, 64'hABCD, 64'h0, 1'b0);
    check_eq("ins_stat", 64'(stat), 64'd4);
    tick();
    check_eq("ins_halted", 64'(halted), 64'd1);
    drive(4'h5, 64'h30);
    check_eq("ins_nowrite", valM, 64'h0);
    check_eq("ins_stat_held", 64'(stat), 64'd4);
    pulse_reset();

    // Wrapping push address is an error and must not alias into the RAM
    drive(4'hA, 64'hFFFF_FFFF_FFFF_FFF8, 64'h77);
    check_eq("wrap_dmem", 64'(dmem_error), 64'd1);
    check_eq("wrap_stat", 64'(stat), 64'd3);
    tick();
    check_eq("wrap_halted", 64'(halted), 64'd1);
    drive(4'h5, 64'h3F8);
    check_eq("wrap_nowrite", valM, 64'h0);
    pulse_reset();

    // Fault and store in the same cycle
    drive(4'h4, 64'h60, 64'h66, 64'h0, 1'b1, 1'b1);
    check_eq("sim_stat", 64'(stat), 64'd3);
    tick();
    check_eq("sim_halted", 64'(halted), 64'd1);
    drive(4'h5, 64'h60);
    check_eq("sim_nowrite", valM, 64'h0);
    pulse_reset();

    // Async reset after storing data, while halted
    drive(4'h4, 64'h40, 64'hCAFE);
    tick();
    drive(4'h0);
    tick();
    drive(4'h5, 64'h40);
    check_eq("ar_halted_read", valM, 64'hCAFE);
    #2 reset_n = 1'b0;
    #1;
    check_eq("ar_valM", valM, 64'h0);
    check_eq("ar_stat", 64'(stat), 64'd1);
    check_eq("ar_halted", 64'(halted), 64'd0);
    drive(4'h4, 64'h50, 64'hBEEF);
    tick();
    drive(4'h1);
    reset_n = 1'b1;
    drive(4'h5, 64'h40);
    check_eq("ar_cleared", valM, 64'h0);
    drive(4'h5, 64'h50);
    check_eq("ar_dropped", valM, 64'h0);
    check_eq("ar_run_stat", 64'(stat), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
